mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 8:1 bit multiplexer among eight requesters. It samples eight request lines, grants one requester at a time and drives the 3-bit select that steers that requester's data bit onto the shared output. It sits directly in front of the mux: its select output connects straight to the mux control input. A programmable hold limit bounds how long one requester can keep the mux.

---
 rtl/mux_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving the select of a shared 8:1 bit mux
// Optional high-priority request class enabled by defining MUX_ARB_PRIO_EN.
module mux_rr_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [7:0] req,
`ifdef MUX_ARB_PRIO_EN
    input  logic [7:0] prio,
`endif
    output logic [2:0] addr,
    output logic [7:0] grant,
    output logic       valid
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_addr;
    logic [7:0] r_grant;
    logic       r_valid;
    logic [7:0] r_hold_cnt;
    logic [2:0] r_ptr;

    state_t     w_state;
    logic [2:0] w_addr;
    logic [7:0] w_grant;
    logic       w_valid;
    logic [7:0] w_hold_cnt;
    logic [2:0] w_ptr;
    logic [7:0] w_mask;
    logic       w_found;
    logic [2:0] w_win;
    logic       w_take;

    // Candidate set: high-priority requests if any exist, otherwise every request.
    always_comb begin
        w_mask = req;
`ifdef MUX_ARB_PRIO_EN
        if ((req & prio) != 8'h00) begin
            w_mask = req & prio;
        end
`endif
        w_found = 1'b0;
        w_win   = r_ptr;
        // k=8 wraps back onto the pointer itself so a lone requester can be re-granted.
        for (int k = 1; k <= 8; k++) begin
            if (!w_found && w_mask[3'(r_ptr + 3'(k))]) begin
                w_found = 1'b1;
                w_win   = 3'(r_ptr + 3'(k));
            end
        end
    end

    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_grant    = r_grant;
        w_valid    = r_valid;
        w_hold_cnt = r_hold_cnt;
        w_ptr      = r_ptr;
        w_take     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_take = 1'b1;
                end
            end
            S_GRANT: begin
                if (!req[r_addr] || (r_hold_cnt == HOLD_LAST)) begin
                    if (w_found) begin
                        w_take = 1'b1;
                    end else begin
                        w_state = S_IDLE;
                        w_grant = 8'h00;
                        w_valid = 1'b0;
                    end
                end else begin
                    w_hold_cnt = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_grant = 8'h00;
                w_valid = 1'b0;
            end
        endcase
        if (w_take) begin
            w_state    = S_GRANT;
            w_addr     = w_win;
            w_grant    = 8'b1 << w_win;
            w_valid    = 1'b1;
            w_hold_cnt = 8'h00;
            w_ptr      = w_win;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state    <= S_IDLE;
            r_addr     <= 3'd0;
            r_grant    <= 8'h00;
            r_valid    <= 1'b0;
            r_hold_cnt <= 8'h00;
            r_ptr      <= 3'd7;
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_grant    <= w_grant;
            r_valid    <= w_valid;
            r_hold_cnt <= w_hold_cnt;
            r_ptr      <= w_ptr;
        end
    end

    assign addr  = r_addr;
    assign grant = r_grant;
    assign valid = r_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

    localparam int HOLD = 4;

    logic       clk;
    logic       rstN;
    logic [7:0] req;
    logic [7:0] prio;
    logic [2:0] addr;
    logic [7:0] grant;
    logic       valid;

    int checks;
    int errors;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] grant;
        logic       valid;
    } exp_t;

    exp_t exp_q[$];

    // Reference state
    int  m_addr;
    int  m_ptr;
    int  m_cnt;
    bit  m_busy;

    mux_rr_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rstN  (rstN),
        .req   (req),
`ifdef MUX_ARB_PRIO_EN
        .prio  (prio),
`endif
        .addr  (addr),
        .grant (grant),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input logic [7:0] p);
        logic [7:0] cand;
        cand = r;
`ifdef MUX_ARB_PRIO_EN
        if ((r & p) != 8'h00) cand = r & p;
`endif
        for (int k = 1; k <= 8; k++) begin
            if (cand[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [7:0] r, input logic rn, input logic [7:0] p);
        exp_t e;
        int   w;
        bit   rel;
        if (!rn) begin
            m_addr = 0; m_ptr = 7; m_cnt = 0; m_busy = 0;
        end else begin
            rel = !m_busy || !r[m_addr] || (m_cnt == HOLD - 1);
            if (rel) begin
                w = pick(r, p);
                if (w >= 0) begin
                    m_addr = w; m_ptr = w; m_cnt = 0; m_busy = 1;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_cnt++;
            end
        end
        e.addr  = 3'(m_addr);
        e.grant = m_busy ? (8'h01 << m_addr) : 8'h00;
        e.valid = m_busy;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [7:0] r, input logic rn, input logic [7:0] p);
        exp_t e;
        req  = r;
        rstN = rn;
        prio = p;
        model_edge(r, rn, p);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("addr", 32'(addr), 32'(e.addr));
            check("grant", 32'(grant), 32'(e.grant));
            check("valid", 32'(valid), 32'(e.valid));
            check("onehot", 32'($countones(grant) <= 1), 32'd1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        req    = 8'h00;
        rstN   = 1'b0;
        prio   = 8'h00;
        m_addr = 0; m_ptr = 7; m_cnt = 0; m_busy = 0;
        #1;

        step(8'h00, 1'b0, 8'h00);
        step(8'h5A, 1'b0, 8'h00);
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);

        // Single requester: 4-cycle grants re-issued back to back
        for (int i = 0; i < 12; i++) begin
            step(8'h01, 1'b1, 8'h00);
            check("single_grant", 32'(grant), 32'h01);
        end

        // All requesters: each address held for HOLD cycles, 0..7 then wrap
        step(8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 36; i++) begin
            step(8'hFF, 1'b1, 8'h00);
            check("rr_addr", 32'(addr), 32'((i / HOLD) % 8));
            check("rr_valid", 32'(valid), 32'd1);
        end

        // Handover 3 -> 5 with no idle cycle
        step(8'h00, 1'b0, 8'h00);
        step(8'h08, 1'b1, 8'h00);
        step(8'h08, 1'b1, 8'h00);
        step(8'h20, 1'b1, 8'h00);
        check("handover_grant", 32'(grant), 32'h20);
        check("handover_addr", 32'(addr), 32'd5);

        // Idle keeps addr; next scan starts after 6
        step(8'h00, 1'b0, 8'h00);
        step(8'h40, 1'b1, 8'h00);
        step(8'h00, 1'b1, 8'h00);
        check("idle_addr", 32'(addr), 32'd6);
        check("idle_valid", 32'(valid), 32'd0);
        step(8'h41, 1'b1, 8'h00);
        check("after_idle_addr", 32'(addr), 32'd0);

        // Reset while requester 2 holds the mux
        step(8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) step(8'hFF, 1'b1, 8'h00);
        check("pre_reset_addr", 32'(addr), 32'd2);
        step(8'hFF, 1'b0, 8'h00);
        check("midreset_grant", 32'(grant), 32'h00);
        check("midreset_addr", 32'(addr), 32'd0);
        step(8'hFF, 1'b1, 8'h00);
        check("post_reset_grant", 32'(grant), 32'h01);

`ifdef MUX_ARB_PRIO_EN
        step(8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 24; i++) begin
            step(8'hFF, 1'b1, 8'h90);
            check("prio_addr", 32'(addr), ((i / HOLD) % 2 == 0) ? 32'd4 : 32'd7);
        end
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r;
            logic [7:0] p;
            logic       rn;
            r  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
            if ($urandom_range(0, 9) == 0) r = 8'h00;
            p  = 8'($urandom) & 8'($urandom);
            rn = ($urandom_range(0, 49) != 0);
            step(r, rn, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
